// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM image loader.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_SUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned LEN_BYTES_DEF = 4;
  localparam logic [7:0]  CHK_SEED      = 8'h00;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write port of the loader, bundled as one interface.
interface rom_loader_if #(
  parameter int unsigned ROM_ADDR = 8
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                mem_we;
  logic [ROM_ADDR-1:0] mem_addr;
  logic [7:0]          mem_wdata;

  // Host side: supplies the stream, observes the ROM writes.
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rom_loader_len.sv
// Little-endian length-header shift register with full-width oversize compare.
module rom_loader_len #(
  parameter int unsigned ROM_ADDR  = 8,
  parameter int unsigned LEN_BYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                shift,
  input  logic [7:0]          byte_in,
  output logic                hdr_last,
  output logic                oversize,
  output logic                len_zero,
  output logic [ROM_ADDR:0]   length
);
  localparam int unsigned W  = 8 * LEN_BYTES;
  localparam int unsigned CW = ROM_ADDR + 1;
  localparam int unsigned XW = (W > CW) ? W : CW;
  localparam logic [XW-1:0] CAP = {{(XW-1){1'b0}}, 1'b1} << ROM_ADDR;

  logic [W-1:0]  len_q;
  logic [W-1:0]  len_full;
  logic [XW-1:0] full_x;
  logic [2:0]    idx_q;
  logic          idx_last;

  // Value the header will hold once the current byte is shifted in.
  generate
    if (W == 8) begin : g_one
      assign len_full = byte_in;
    end else begin : g_many
      assign len_full = {byte_in, len_q[W-1:8]};
    end
    if (W >= CW) begin : g_trunc
      assign length = len_q[CW-1:0];
    end else begin : g_ext
      assign length = {{(CW-W){1'b0}}, len_q};
    end
  endgenerate

  assign full_x   = XW'(len_full);
  assign idx_last = (idx_q == 3'(LEN_BYTES - 1));
  assign hdr_last = shift && idx_last;
  assign oversize = (full_x > CAP);
  assign len_zero = (len_full == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q <= '0;
      idx_q <= '0;
    end else if (clear) begin
      len_q <= '0;
      idx_q <= '0;
    end else if (shift) begin
      len_q <= len_full;
      idx_q <= idx_last ? 3'd0 : idx_q + 3'd1;
    end
  end
endmodule

// File: rtl/rom_loader.sv
// Streams a length-prefixed program image into the CPU code ROM, holding the CPU in reset.
// Optional trailing XOR checksum enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ROM_ADDR  = 8,
  parameter int unsigned LEN_BYTES = LEN_BYTES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  rom_loader_if.slave bus,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = ST_SUM;
`else
  localparam state_t AFTER_PAYLOAD = ST_DONE;
`endif

  state_t              state_q, state_n;
  logic [ROM_ADDR:0]   count_q;
  logic [ROM_ADDR:0]   length;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ROM_ADDR-1:0] mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic                done_q, error_q, cpu_reset_q;
  logic                accept, restart, hdr_last, oversize, len_zero, data_last;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]          acc_q;
`endif

  assign accept    = bus.in_valid && in_ready_q;
  assign restart   = start && (state_q == ST_DONE || state_q == ST_ERROR);
  assign data_last = ((count_q + 1'b1) == length);

  rom_loader_len #(
    .ROM_ADDR  (ROM_ADDR),
    .LEN_BYTES (LEN_BYTES)
  ) u_len (
    .clk      (clk),
    .reset    (reset),
    .clear    (restart),
    .shift    (accept && state_q == ST_LEN),
    .byte_in  (bus.in_data),
    .hdr_last (hdr_last),
    .oversize (oversize),
    .len_zero (len_zero),
    .length   (length)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_LEN;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_LEN: begin
        if (hdr_last) begin
          if (oversize)      state_n = ST_ERROR;
          else if (len_zero) state_n = AFTER_PAYLOAD;
          else               state_n = ST_DATA;
        end
      end
      ST_DATA:  if (accept && data_last) state_n = AFTER_PAYLOAD;
      ST_SUM: begin
`ifdef ROM_LOADER_CHECKSUM_EN
        if (accept) state_n = (bus.in_data == acc_q) ? ST_DONE : ST_ERROR;
`else
        state_n = ST_ERROR;
`endif
      end
      ST_DONE, ST_ERROR: if (start) state_n = ST_LEN;
      default: state_n = ST_LEN;
    endcase
  end

  // cpu_reset drops only once DONE has been held for a cycle, after the final write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
      if (restart) begin
        count_q <= '0;
      end else if (accept && state_q == ST_DATA) begin
        count_q     <= count_q + 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= count_q[ROM_ADDR-1:0];
        mem_wdata_q <= bus.in_data;
      end
      in_ready_q  <= (state_n == ST_LEN || state_n == ST_DATA || state_n == ST_SUM);
      done_q      <= (state_n == ST_DONE);
      error_q     <= (state_n == ST_ERROR);
      cpu_reset_q <= !(state_q == ST_DONE && state_n == ST_DONE);
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             acc_q <= CHK_SEED;
    else if (restart)                      acc_q <= CHK_SEED;
    else if (accept && state_q == ST_DATA) acc_q <= acc_q ^ bus.in_data;
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign done          = done_q;
  assign error         = error_q;
  assign cpu_reset     = cpu_reset_q;
endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader (ROM_ADDR=8, LEN_BYTES=4).
module tb_rom_loader;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_reset, done, error;

  rom_loader_if #(.ROM_ADDR(8)) bus ();

  rom_loader #(.ROM_ADDR(8), .LEN_BYTES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  logic [7:0] wr_addr [0:511];
  logic [7:0] wr_data [0:511];
  int         wr_cyc  [0:511];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we === 1'b1 && wr_cnt < 512) begin
      wr_addr[wr_cnt] = bus.mem_addr;
      wr_data[wr_cnt] = bus.mem_wdata;
      wr_cyc[wr_cnt]  = cyc;
      wr_cnt = wr_cnt + 1;
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout byte=%h in_ready=%b want=1", b, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", bus.mem_we); end
    total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL rst_mem_addr got=%h want=00", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 8'h00) begin bad++; $display("FAIL rst_mem_wdata got=%h want=00", bus.mem_wdata); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset got=%b want=1", cpu_reset); end
    total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b want=00", done, error); end
  endtask

  task automatic test_good_frame();
    logic [7:0] pl [0:3];
    int base = wr_cnt;
    pl[0] = 8'h20; pl[1] = 8'h00; pl[2] = 8'h41; pl[3] = 8'h01;
    send_hdr(32'd4);
    for (int i = 0; i < 4; i++) send_byte(pl[i]);
    if (CHK) send_byte(8'h60);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL good_done got=%b want=1", done); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL good_cpu_reset_hold got=%b want=1", cpu_reset); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL good_in_ready got=%b want=0", bus.in_ready); end
    @(negedge clk);
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL good_cpu_reset_rel got=%b want=0", cpu_reset); end
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL good_flags got=%b%b want=10", done, error); end
    total++; if (wr_cnt - base !== 4) begin bad++; $display("FAIL good_wr_cnt got=%0d want=4", wr_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== pl[i]) begin
        bad++;
        $display("FAIL good_write%0d got=%h:%h want=%h:%h", i, wr_addr[base+i], wr_data[base+i], 8'(i), pl[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_cyc[base+i+1] - wr_cyc[base+i] !== 1) begin
        bad++;
        $display("FAIL good_b2b%0d gap got=%0d want=1", i, wr_cyc[base+i+1] - wr_cyc[base+i]);
      end
    end
    pulse_start();
  endtask

`ifdef ROM_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    int base = wr_cnt;
    send_hdr(32'd4);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h41); send_byte(8'h01);
    send_byte(8'h61);
    @(negedge clk);
    total++; if (wr_cnt - base !== 4) begin bad++; $display("FAIL badsum_wr_cnt got=%0d want=4", wr_cnt - base); end
    total++; if (error !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL badsum_flags got=e%b d%b want=e1 d0", error, done); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL badsum_cpu_reset got=%b want=1", cpu_reset); end
    pulse_start();
  endtask
`endif

  task automatic test_oversize(input logic [31:0] n);
    int base = wr_cnt;
    send_hdr(n);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL over_%0h_error got=%b want=1", n, error); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL over_%0h_in_ready got=%b want=0", n, bus.in_ready); end
    @(negedge clk);
    total++; if (wr_cnt - base !== 0 || done !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++; $display("FAIL over_%0h_state got=w%0d d%b c%b want=w0 d0 c1", n, wr_cnt - base, done, cpu_reset);
    end
    pulse_start();
  endtask

  task automatic test_zero_length();
    int base = wr_cnt;
    send_hdr(32'd0);
    if (CHK) send_byte(8'h00);
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL zero_flags got=d%b e%b want=d1 e0", done, error); end
    @(negedge clk);
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL zero_wr_cnt got=%0d want=0", wr_cnt - base); end
    pulse_start();
  endtask

  task automatic test_full_capacity();
    int base = wr_cnt;
    send_hdr(32'd256);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    if (CHK) send_byte(8'h00);
    @(negedge clk);
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL full_flags got=d%b e%b want=d1 e0", done, error); end
    total++; if (wr_cnt - base !== 256) begin bad++; $display("FAIL full_wr_cnt got=%0d want=256", wr_cnt - base); end
    total++; if (wr_addr[base+255] !== 8'hFF || wr_data[base+255] !== 8'hFF) begin
      bad++; $display("FAIL full_last got=%h:%h want=ff:ff", wr_addr[base+255], wr_data[base+255]);
    end
    pulse_start();
  endtask

  task automatic test_gaps();
    int base = wr_cnt;
    send_hdr(32'd3);
    send_byte(8'hAA); @(negedge clk);
    send_byte(8'hBB); @(negedge clk);
    send_byte(8'hCC);
    if (CHK) send_byte(8'hDD);
    @(negedge clk);
    total++; if (wr_cnt - base !== 3 || done !== 1'b1) begin bad++; $display("FAIL gap_summary got=w%0d d%b want=w3 d1", wr_cnt - base, done); end
    total++; if (wr_addr[base] !== 8'h00 || wr_addr[base+1] !== 8'h01 || wr_addr[base+2] !== 8'h02) begin
      bad++; $display("FAIL gap_addr got=%h,%h,%h want=00,01,02", wr_addr[base], wr_addr[base+1], wr_addr[base+2]);
    end
    total++; if (wr_data[base] !== 8'hAA || wr_data[base+1] !== 8'hBB || wr_data[base+2] !== 8'hCC) begin
      bad++; $display("FAIL gap_data got=%h,%h,%h want=aa,bb,cc", wr_data[base], wr_data[base+1], wr_data[base+2]);
    end
    total++; if (wr_cyc[base+1] - wr_cyc[base] !== 2) begin bad++; $display("FAIL gap_spacing got=%0d want=2", wr_cyc[base+1] - wr_cyc[base]); end
    pulse_start();
  endtask

  task automatic test_reset_mid();
    int base;
    send_hdr(32'd4);
    send_byte(8'h11); send_byte(8'h22);
    reset = 1'b1;
    #1;
    total++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
      bad++; $display("FAIL mid_mem got=%b %h %h want=0 00 00", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    total++; if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_ctrl got=c%b d%b e%b r%b want=c1 d0 e0 r1", cpu_reset, done, error, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    send_hdr(32'd1);
    send_byte(8'h7F);
    if (CHK) send_byte(8'h7F);
    @(negedge clk);
    total++; if (wr_cnt - base !== 1 || wr_addr[base] !== 8'h00 || wr_data[base] !== 8'h7F) begin
      bad++; $display("FAIL mid_reload got=w%0d %h:%h want=w1 00:7f", wr_cnt - base, wr_addr[base], wr_data[base]);
    end
    total++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin bad++; $display("FAIL mid_done got=d%b c%b want=d1 c0", done, cpu_reset); end
    pulse_start();
    total++; if (cpu_reset !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_rearm got=c%b d%b r%b want=c1 d0 r1", cpu_reset, done, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
`ifdef ROM_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_oversize(32'h0000_0101);
    test_oversize(32'h0001_0000);
    test_zero_length();
    test_full_capacity();
    test_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cycles=%0d limit reached", cyc);
    $fatal(1);
  end
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer side of the CPU code ROM: receives a program image over a byte-stream valid/ready interface and writes it byte-by-byte into the ROM write port.
- Holds the CPU in reset (cpu_reset) while loading; releases it only after a complete, well-formed image.
- Lets benches and boards load wasm programs at run time instead of from a hex file at elaboration.

Parameters:
- ROM_ADDR, 8, ROM address width in bits; capacity = 2^ROM_ADDR bytes.
- LEN_BYTES, 4, number of little-endian length-header bytes (1..4).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  re-arm pulse; honoured only in DONE or ERROR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  ROM write strobe, one cycle per byte.
- mem_addr  output  ROM_ADDR  ROM write address.
- mem_wdata  output  8  ROM write data.
- cpu_reset  output  1  reset to the CPU; high while not loaded.
- done  output  1  image loaded successfully.
- error  output  1  image rejected.

Behaviour:
- Frame format: LEN_BYTES length bytes, LSB first (N); then N payload bytes; then one checksum byte (feature-dependent).
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_data must be held while in_valid && !in_ready.
- States:
  - LEN: in_ready=1. Shift in length bytes. On the last one:
    - N > 2^ROM_ADDR -> ERROR.
    - N == 0 -> SUM, or DONE when the checksum feature is absent.
    - otherwise -> DATA.
  - DATA: in_ready=1. Each accepted byte registers mem_we=1, mem_addr=count, mem_wdata=in_data for exactly the next cycle; count increments. Back-to-back accepts give continuous writes. After byte N-1 -> SUM, or DONE when the checksum feature is absent.
  - SUM: in_ready=1. Accept one byte. Equal to the XOR of all payload bytes -> DONE; else -> ERROR.
  - DONE: in_ready=0; done=1.
  - ERROR: in_ready=0; error=1; cpu_reset stays 1.
- DONE/ERROR exit: start=1 -> LEN, clearing count, length, checksum accumulator, done and error. Same cycle cpu_reset returns to 1. start is ignored in LEN/DATA/SUM.
- Outputs are registered from state:
  - done rises on the edge entering DONE.
  - cpu_reset falls one cycle after done rises, so the last mem_we has committed before the CPU runs.
- Reset: asynchronous. State=LEN, count=0, length=0, acc=0, in_ready=1 after reset release, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0.
- Reset mid-load: the load is abandoned; the partially written ROM is not cleared.
- N == 2^ROM_ADDR is legal: the last address is all-ones. The counter must be ROM_ADDR+1 bits wide; no wrap-around write.
- Length bytes beyond the counter width are compared in full. No truncation.

Optional Feature:
- ROM_LOADER_CHECKSUM_EN.
- Defined: SUM state present; the trailing XOR checksum is required; a mismatch goes to ERROR.
- Undefined: no SUM state and no checksum byte. The frame ends after payload byte N-1 (or after the header when N=0), going directly to DONE. ERROR is reachable only by oversize length.

Decomposition:
- Shared package (rom_loader_pkg):
  - state encoding: LEN, DATA, SUM, DONE, ERROR.
  - default constant LEN_BYTES=4.
  - checksum seed constant 8'h00.
- One natural sub-module: rom_loader_len (length-header shift register plus oversize compare).

Test Plan:
- Checksum enabled, ROM_ADDR=8: stream 04 00 00 00 | 20 00 41 01 | checksum 60.
  - Four mem_we pulses: addr 0..3, data 20,00,41,01.
  - done=1, then cpu_reset=0 one cycle later; error=0.
- Same frame with checksum 61:
  - Four writes occur; error=1, done=0, cpu_reset stays 1.
- Length 01 01 00 00 (257) with ROM_ADDR=8:
  - ERROR right after the fourth header byte; no mem_we; in_ready=0.
- Length 00 00 00 00, checksum 00 -> done=1 with zero writes. With the checksum feature absent -> done immediately after the header.
- in_valid toggled 1,0,1,0 during DATA:
  - writes occur only after accepted bytes; addresses are contiguous.
- Reset asserted mid-DATA after 2 of 4 bytes:
  - outputs immediately at reset values.
  - New frame 01 00 00 00 | 7F | 7F loads 7F at addr 0 -> done.
  - Then start -> cpu_reset=1, done=0, in_ready=1.
